// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the hazard controller
package hazard_controller_pkg;

    typedef enum logic {
        HC_RUN   = 1'b0,
        HC_STALL = 1'b1
    } hc_state_t;

    // Number of bubbles a hazard in ID requires.
    typedef logic [1:0] need_t;

    localparam need_t NEED_NONE = 2'd0;
    localparam need_t NEED_ONE  = 2'd1;
    localparam need_t NEED_TWO  = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational hazard classification from ID/EX/MEM fields
module hazard_detect
    import hazard_controller_pkg::*;
(
    input  logic [4:0] IF_ID_rs1,
    input  logic [4:0] IF_ID_rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       branch,
    input  logic       jalr,
    input  logic [4:0] ID_EX_rd,
    input  logic       ID_EX_regwrite,
    input  logic       ID_EX_memread,
    input  logic [4:0] EX_MEM_rd,
    input  logic       EX_MEM_memread,
    output need_t      need
);

    logic match_ex;
    logic match_mem;
    logic id_resolved;

    // x0 never carries a dependency; only sources the ID instruction reads count.
    assign match_ex  = (ID_EX_rd != REG_X0) &&
                       ((use_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                        (use_rs2 && (ID_EX_rd == IF_ID_rs2)));
    assign match_mem = (EX_MEM_rd != REG_X0) &&
                       ((use_rs1 && (EX_MEM_rd == IF_ID_rs1)) ||
                        (use_rs2 && (EX_MEM_rd == IF_ID_rs2)));
    assign id_resolved = branch | jalr;

    // Load feeding an ID-resolved compare needs the data out of MEM, so two bubbles.
    always_comb begin
        need = NEED_NONE;
        if (id_resolved && ID_EX_memread && match_ex) begin
            need = NEED_TWO;
        end else if ((ID_EX_memread && match_ex) ||
                     (id_resolved && ID_EX_regwrite && match_ex) ||
                     (id_resolved && EX_MEM_memread && match_mem)) begin
            need = NEED_ONE;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall FSM, pipeline enables, flush and perf counters
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             branch,
    input  logic             jalr,
    input  logic             ctrl_taken,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_regwrite,
    input  logic             ID_EX_memread,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_memread,
    input  logic             ICACHE_stall,
    input  logic             DCACHE_stall,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hc_state_t  state;
    hc_state_t  state_next;
    logic [1:0] left;
    logic [1:0] left_next;
    need_t      need;
    logic       freeze;
    logic       stall;
    logic       flush;

    hazard_detect u_detect (
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .use_rs1        (use_rs1),
        .use_rs2        (use_rs2),
        .branch         (branch),
        .jalr           (jalr),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_regwrite (ID_EX_regwrite),
        .ID_EX_memread  (ID_EX_memread),
        .EX_MEM_rd      (EX_MEM_rd),
        .EX_MEM_memread (EX_MEM_memread),
        .need           (need)
    );

    assign freeze = ICACHE_stall | DCACHE_stall;
    assign stall  = ~freeze & (((state == HC_RUN) & (need != NEED_NONE)) | (state == HC_STALL));
    // A stalled branch resolved on stale operands, so its taken decision is discarded.
    assign flush  = ctrl_taken & ~stall & ~freeze;

    // Enables are forced low while reset is held so nothing advances out of reset garbage.
    assign pc_write     = ~rst & ~freeze & ~stall;
    assign IF_ID_write  = ~rst & ~freeze & ~stall;
    assign ID_EX_write  = ~rst & ~freeze;
    assign EX_MEM_write = ~rst & ~freeze;
    assign MEM_WB_write = ~rst & ~freeze;
    assign ID_EX_bubble = ~rst & stall;
    assign IF_ID_flush  = ~rst & flush;

    // Next state: a freeze holds everything; STALL counts down its remaining bubbles.
    always_comb begin
        state_next = state;
        left_next  = left;
        if (!freeze) begin
            case (state)
                HC_RUN: begin
                    if (need == NEED_TWO) begin
                        state_next = HC_STALL;
                        left_next  = 2'd1;
                    end
                end
                HC_STALL: begin
                    left_next = left - 2'd1;
                    if (left_next == 2'd0) begin
                        state_next = HC_RUN;
                    end
                end
                default: begin
                    state_next = HC_RUN;
                    left_next  = 2'd0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HC_RUN;
            left  <= 2'd0;
        end else begin
            state <= state_next;
            left  <= left_next;
        end
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (stall | freeze) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  IF_ID_rs1, IF_ID_rs2;
    logic        use_rs1, use_rs2, branch, jalr, ctrl_taken;
    logic [4:0]  ID_EX_rd;
    logic        ID_EX_regwrite, ID_EX_memread;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_memread;
    logic        ICACHE_stall, DCACHE_stall;
    logic        pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic        ID_EX_bubble, IF_ID_flush;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int checks = 0;
    int fails  = 0;

    hazard_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .use_rs1(use_rs1), .use_rs2(use_rs2),
        .branch(branch), .jalr(jalr), .ctrl_taken(ctrl_taken),
        .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
        .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
        .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        branch = 1'b0; jalr = 1'b0; ctrl_taken = 1'b0;
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0;
        ICACHE_stall = 1'b0; DCACHE_stall = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    // lw x5 in EX, beq x5,x0 in ID
    task automatic set_load_branch();
        branch = 1'b1; IF_ID_rs1 = 5'd5; use_rs1 = 1'b1; IF_ID_rs2 = 5'd0; use_rs2 = 1'b1;
        ID_EX_rd = 5'd5; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        checks++; if ({pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, ID_EX_bubble, IF_ID_flush} !== 7'b0) begin
            fails++; $display("FAIL rst_outputs got %b exp 0000000", {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, ID_EX_bubble, IF_ID_flush}); end
        step();
        rst = 1'b0;
        #1;
        checks++; if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'd0) begin
            fails++; $display("FAIL rst_counters got %0d/%0d/%0d exp 0/0/0", cycle_cnt, stall_cnt, flush_cnt); end
        checks++; if ({pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble} !== 4'b1110) begin
            fails++; $display("FAIL rst_release_en got %b exp 1110", {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble}); end
        step();
        checks++; if (cycle_cnt !== 32'd1) begin
            fails++; $display("FAIL rst_first_cycle got %0d exp 1", cycle_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        // lw x5 in EX, add x6,x5,x1 in ID
        IF_ID_rs1 = 5'd5; IF_ID_rs2 = 5'd1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        ID_EX_rd = 5'd5; ID_EX_regwrite = 1'b1; ID_EX_memread = 1'b1;
        #1;
        checks++; if ({pc_write, IF_ID_write, ID_EX_bubble, ID_EX_write} !== 4'b0011) begin
            fails++; $display("FAIL lu_stall got %b exp 0011", {pc_write, IF_ID_write, ID_EX_bubble, ID_EX_write}); end
        step();
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd5; EX_MEM_memread = 1'b1;
        #1;
        checks++; if ({pc_write, IF_ID_write, ID_EX_bubble} !== 3'b110) begin
            fails++; $display("FAIL lu_resume got %b exp 110", {pc_write, IF_ID_write, ID_EX_bubble}); end
        step();
        checks++; if (stall_cnt !== 32'd1) begin
            fails++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
    endtask

    task automatic test_load_branch();
        do_reset();
        set_load_branch();
        ctrl_taken = 1'b1;
        #1;
        checks++; if ({ID_EX_bubble, IF_ID_flush, pc_write} !== 3'b100) begin
            fails++; $display("FAIL lb_c1 got %b exp 100", {ID_EX_bubble, IF_ID_flush, pc_write}); end
        step();
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd5; EX_MEM_memread = 1'b1;
        #1;
        checks++; if (dut.state !== HC_STALL) begin
            fails++; $display("FAIL lb_c2_state got %b exp %b", dut.state, HC_STALL); end
        checks++; if ({ID_EX_bubble, IF_ID_flush} !== 2'b10) begin
            fails++; $display("FAIL lb_c2 got %b exp 10", {ID_EX_bubble, IF_ID_flush}); end
        step();
        EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0;
        #1;
        checks++; if ({ID_EX_bubble, IF_ID_flush, pc_write} !== 3'b011) begin
            fails++; $display("FAIL lb_c3 got %b exp 011", {ID_EX_bubble, IF_ID_flush, pc_write}); end
        step();
        clear_inputs();
        #1;
        checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin
            fails++; $display("FAIL lb_counts got flush=%0d stall=%0d exp flush=1 stall=2", flush_cnt, stall_cnt); end
    endtask

    task automatic test_freeze_in_stall();
        do_reset();
        set_load_branch();
        step();
        ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
        EX_MEM_rd = 5'd5; EX_MEM_memread = 1'b1;
        DCACHE_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, ID_EX_bubble} !== 6'b0) begin
                fails++; $display("FAIL fz_en[%0d] got %b exp 000000", i, {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, ID_EX_bubble}); end
            checks++; if (dut.left !== 2'd1 || dut.state !== HC_STALL) begin
                fails++; $display("FAIL fz_hold[%0d] got left=%0d state=%b exp left=1 state=1", i, dut.left, dut.state); end
            step();
        end
        DCACHE_stall = 1'b0;
        #1;
        checks++; if ({ID_EX_bubble, pc_write, ID_EX_write} !== 3'b101) begin
            fails++; $display("FAIL fz_last_bubble got %b exp 101", {ID_EX_bubble, pc_write, ID_EX_write}); end
        step();
        clear_inputs();
        #1;
        checks++; if (ID_EX_bubble !== 1'b0 || dut.state !== HC_RUN) begin
            fails++; $display("FAIL fz_done got bubble=%b state=%b exp bubble=0 state=0", ID_EX_bubble, dut.state); end
        checks++; if (stall_cnt !== 32'd5) begin
            fails++; $display("FAIL fz_stall_cnt got %0d exp 5", stall_cnt); end
    endtask

    task automatic test_icache_flush();
        do_reset();
        ctrl_taken = 1'b1;
        ICACHE_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({IF_ID_flush, pc_write} !== 2'b00) begin
                fails++; $display("FAIL ic_frozen[%0d] got %b exp 00", i, {IF_ID_flush, pc_write}); end
            step();
        end
        ICACHE_stall = 1'b0;
        #1;
        checks++; if ({IF_ID_flush, pc_write} !== 2'b11) begin
            fails++; $display("FAIL ic_flush got %b exp 11", {IF_ID_flush, pc_write}); end
        step();
        ctrl_taken = 1'b0;
        #1;
        checks++; if (IF_ID_flush !== 1'b0 || flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin
            fails++; $display("FAIL ic_after got flush=%b fcnt=%0d scnt=%0d exp 0/1/2", IF_ID_flush, flush_cnt, stall_cnt); end
    endtask

    task automatic test_no_stall();
        do_reset();
        // load writing x0 read by ID
        ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; use_rs1 = 1'b1;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b01) begin
            fails++; $display("FAIL ns_x0_load got %b exp 01", {ID_EX_bubble, pc_write}); end
        // load matches rs2 only, but rs2 is not read
        ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd7; use_rs2 = 1'b0;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b01) begin
            fails++; $display("FAIL ns_rs2_unused got %b exp 01", {ID_EX_bubble, pc_write}); end
        // branch against an x0-writing load in MEM
        clear_inputs();
        jalr = 1'b1; use_rs1 = 1'b1; IF_ID_rs1 = 5'd0; EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b1;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b01) begin
            fails++; $display("FAIL ns_x0_mem got %b exp 01", {ID_EX_bubble, pc_write}); end
    endtask

    task automatic test_branch_single();
        do_reset();
        // ALU result in EX feeding a branch: one bubble, no STALL state
        branch = 1'b1; use_rs2 = 1'b1; IF_ID_rs2 = 5'd8; ID_EX_rd = 5'd8; ID_EX_regwrite = 1'b1;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b10) begin
            fails++; $display("FAIL bs_alu got %b exp 10", {ID_EX_bubble, pc_write}); end
        step();
        checks++; if (dut.state !== HC_RUN) begin
            fails++; $display("FAIL bs_alu_state got %b exp 0", dut.state); end
        // load in MEM feeding a jalr: one bubble
        clear_inputs();
        jalr = 1'b1; use_rs1 = 1'b1; IF_ID_rs1 = 5'd9; EX_MEM_rd = 5'd9; EX_MEM_memread = 1'b1;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b10) begin
            fails++; $display("FAIL bs_mem got %b exp 10", {ID_EX_bubble, pc_write}); end
        step();
        EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b01) begin
            fails++; $display("FAIL bs_mem_resume got %b exp 01", {ID_EX_bubble, pc_write}); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_load_branch();
        step();
        checks++; if (dut.state !== HC_STALL) begin
            fails++; $display("FAIL rm_enter got %b exp 1", dut.state); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, ID_EX_bubble, IF_ID_flush} !== 7'b0) begin
            fails++; $display("FAIL rm_outputs got %b exp 0000000", {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, ID_EX_bubble, IF_ID_flush}); end
        checks++; if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'd0 || dut.state !== HC_RUN) begin
            fails++; $display("FAIL rm_state got cnt=%0d/%0d/%0d state=%b exp 0/0/0 state=0", cycle_cnt, stall_cnt, flush_cnt, dut.state); end
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
        checks++; if ({ID_EX_bubble, pc_write} !== 2'b01 || dut.state !== HC_RUN) begin
            fails++; $display("FAIL rm_release got bubble/pc=%b state=%b exp 01 state=0", {ID_EX_bubble, pc_write}, dut.state); end
        step();
        checks++; if (ID_EX_bubble !== 1'b0 || stall_cnt !== 32'd0) begin
            fails++; $display("FAIL rm_no_residual got bubble=%b stall_cnt=%0d exp 0/0", ID_EX_bubble, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_freeze_in_stall();
        test_icache_flush();
        test_no_stall();
        test_branch_single();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
